// File: rtl/mem_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_lock_arbiter
// Description : Round-robin arbiter giving NCH cores access to a single-port
//               RAM, plus an advisory lock table with per-entry owner tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lock_arbiter #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int LW  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    rd_req,
  input  logic [NCH-1:0]    wr_req,
  input  logic [NCH*AW-1:0] req_adr,
  input  logic [NCH*DW-1:0] req_wdat,
  output logic [NCH-1:0]    ac,
  output logic [DW-1:0]     rd_dat,
  input  logic [NCH-1:0]    lock_en,
  input  logic [NCH-1:0]    unlock_en,
  input  logic [NCH*LW-1:0] lock_adr,
  output logic [NCH-1:0]    lock_ac,
  output logic [AW-1:0]     mem_adr,
  output logic [DW-1:0]     mem_wdat,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DW-1:0]     mem_rdat
);

  localparam int c_IDW  = $clog2(NCH);
  localparam int c_NENT = 1 << LW;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state;
  logic [c_IDW-1:0]   r_grant;
  logic [c_IDW-1:0]   r_last;
  logic               r_is_rd;
  logic [NCH-1:0]     r_ac;
  logic [c_NENT-1:0]  r_valid;
  logic [c_IDW-1:0]   r_owner [c_NENT];
  logic [NCH-1:0]     r_lock_ac;

  logic [AW-1:0]      w_adr  [NCH];
  logic [DW-1:0]      w_wdat [NCH];
  logic [LW-1:0]      w_ladr [NCH];
  logic [NCH-1:0]     w_req;
  logic               w_any;
  logic               w_found;
  int                 w_idx;
  logic [c_IDW-1:0]   w_sel;
  logic               w_grant_cyc;
  logic               w_wr;
  logic               w_rd;
  logic [c_NENT-1:0]  w_valid_nx;
  logic [c_NENT-1:0]  w_taken;
  logic [c_IDW-1:0]   w_owner_nx [c_NENT];
  logic [NCH-1:0]     w_lock_ack;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign w_adr[i]  = req_adr[i*AW +: AW];
    assign w_wdat[i] = req_wdat[i*DW +: DW];
    assign w_ladr[i] = lock_adr[i*LW +: LW];
  end

  // Round-robin search begins one past the last served channel
  always_comb begin
    w_req   = rd_req | wr_req;
    w_any   = |w_req;
    w_sel   = r_last;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = (int'(r_last) + k) % NCH;
      if (!w_found && w_req[c_IDW'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = c_IDW'(w_idx);
      end
    end
  end

  // Write wins when a channel raises both requests; its read waits a later grant
  assign w_grant_cyc = (r_state == S_IDLE) && w_any && !reset;
  assign w_wr        = wr_req[w_sel];
  assign w_rd        = rd_req[w_sel] & ~w_wr;
  assign mem_we      = w_grant_cyc & w_wr;
  assign mem_re      = w_grant_cyc & w_rd;
  assign mem_adr     = w_grant_cyc ? w_adr[w_sel]  : '0;
  assign mem_wdat    = w_grant_cyc ? w_wdat[w_sel] : '0;
  assign ac          = r_ac;
  assign rd_dat      = (r_state == S_BUSY && r_is_rd) ? mem_rdat : '0;
  assign lock_ac     = r_lock_ac;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= c_IDW'(NCH - 1);
      r_is_rd <= 1'b0;
      r_ac    <= '0;
    end else begin
      r_ac <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_BUSY;
            r_grant     <= w_sel;
            r_is_rd     <= w_rd;
            r_ac[w_sel] <= 1'b1;
          end
        end
        S_BUSY: begin
          r_state <= S_IDLE;
          r_last  <= r_grant;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Decisions read only the registered table, so a release is visible next cycle
  always_comb begin
    w_valid_nx = r_valid;
    w_owner_nx = r_owner;
    w_lock_ack = '0;
    w_taken    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (unlock_en[i]) begin
        w_lock_ack[i] = 1'b1;
        if (r_valid[w_ladr[i]] && r_owner[w_ladr[i]] == c_IDW'(i))
          w_valid_nx[w_ladr[i]] = 1'b0;
      end else if (lock_en[i] && !w_taken[w_ladr[i]] &&
                   (!r_valid[w_ladr[i]] || r_owner[w_ladr[i]] == c_IDW'(i))) begin
        w_taken[w_ladr[i]]    = 1'b1;
        w_valid_nx[w_ladr[i]] = 1'b1;
        w_owner_nx[w_ladr[i]] = c_IDW'(i);
        w_lock_ack[i]         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_lock_ac <= '0;
      for (int e = 0; e < c_NENT; e++) r_owner[e] <= '0;
    end else begin
      r_valid   <= w_valid_nx;
      r_owner   <= w_owner_nx;
      r_lock_ac <= w_lock_ack;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lock_arbiter
// Description : Directed scoreboard bench for mem_lock_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lock_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LW  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    rd_req, wr_req, lock_en, unlock_en;
  logic [NCH*AW-1:0] req_adr;
  logic [NCH*DW-1:0] req_wdat;
  logic [NCH*LW-1:0] lock_adr;
  logic [NCH-1:0]    ac, lock_ac;
  logic [DW-1:0]     rd_dat, mem_wdat, mem_rdat;
  logic [AW-1:0]     mem_adr;
  logic              mem_we, mem_re;

  mem_lock_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
    .req_adr(req_adr), .req_wdat(req_wdat), .ac(ac), .rd_dat(rd_dat),
    .lock_en(lock_en), .unlock_en(unlock_en), .lock_adr(lock_adr),
    .lock_ac(lock_ac), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdat(mem_rdat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr[7:0]] <= mem_wdat;
    if (mem_re) mem_rdat <= ram[mem_adr[7:0]];
  end

  typedef struct { int cyc; logic [NCH-1:0] vec; logic [DW-1:0] dat; } mexp_t;
  typedef struct { int cyc; logic [NCH-1:0] vec; } lexp_t;
  mexp_t mq[$];
  lexp_t lq[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT shows an acknowledge
  always @(negedge clk) begin
    mexp_t m;
    lexp_t l;
    if (ac != '0) begin
      if (mq.size() == 0) chk("unexpected_ac", 32'(ac), 32'h0);
      else begin
        m = mq.pop_front();
        chk("ac_vec", 32'(ac), 32'(m.vec));
        chk("ac_cycle", cyc, m.cyc);
        chk("rd_dat", 32'(rd_dat), 32'(m.dat));
        chk("mem_strobe_in_busy", {30'h0, mem_re, mem_we}, 32'h0);
      end
    end else begin
      chk("rd_dat_idle", 32'(rd_dat), 32'h0);
    end
    if (lock_ac != '0) begin
      if (lq.size() == 0) chk("unexpected_lock_ac", 32'(lock_ac), 32'h0);
      else begin
        l = lq.pop_front();
        chk("lock_ac_vec", 32'(lock_ac), 32'(l.vec));
        chk("lock_ac_cycle", cyc, l.cyc);
      end
    end
  end

  // Advance one cycle; channels drop what the DUT has just acknowledged
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (ac[i]) begin
        if (wr_req[i]) wr_req[i] = 1'b0;
        else rd_req[i] = 1'b0;
      end
      if (lock_ac[i]) begin
        lock_en[i]   = 1'b0;
        unlock_en[i] = 1'b0;
      end
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mreq(int ch, bit wr, bit rd, logic [AW-1:0] a, logic [DW-1:0] d);
    req_adr[ch*AW +: AW]  = a;
    req_wdat[ch*DW +: DW] = d;
    if (wr) wr_req[ch] = 1'b1;
    if (rd) rd_req[ch] = 1'b1;
  endtask

  task automatic lreq(int ch, bit lk, bit ul, logic [LW-1:0] a);
    lock_adr[ch*LW +: LW] = a;
    if (lk) lock_en[ch]   = 1'b1;
    if (ul) unlock_en[ch] = 1'b1;
  endtask

  task automatic pm(int c, logic [NCH-1:0] v, logic [DW-1:0] d);
    mq.push_back('{c, v, d});
  endtask

  task automatic pl(int c, logic [NCH-1:0] v);
    lq.push_back('{c, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    rd_req = '0; wr_req = '0; lock_en = '0; unlock_en = '0;
    req_adr = '0; req_wdat = '0; lock_adr = '0;
    ticks(2);
    chk("reset_ac", 32'(ac), 32'h0);
    chk("reset_lock_ac", 32'(lock_ac), 32'h0);
    chk("reset_strobes", {30'h0, mem_re, mem_we}, 32'h0);
    reset = 1'b0;
    tick();

    // Write then read back through channel 0
    n = cyc; mreq(0, 1, 0, 16'h0010, 16'h1234); pm(n + 1, 4'b0001, 16'h0);
    ticks(2);
    n = cyc; mreq(0, 0, 1, 16'h0010, 16'h0000); pm(n + 1, 4'b0001, 16'h1234);
    ticks(3);

    // Write precedence when both requests are raised
    n = cyc; mreq(2, 1, 1, 16'h0020, 16'h5A5A);
    pm(n + 1, 4'b0100, 16'h0); pm(n + 3, 4'b0100, 16'h5A5A);
    ticks(5);

    // From a fresh reset all four channels are served in order 0..3
    reset = 1'b1; tick(); reset = 1'b0; tick();
    n = cyc;
    for (int i = 0; i < NCH; i++) mreq(i, 1, 0, 16'(16'h0040 + i), 16'(16'hA000 + i));
    for (int i = 0; i < NCH; i++) pm(n + 1 + 2*i, 4'(1 << i), 16'h0);
    ticks(8);
    n = cyc;
    for (int i = 0; i < NCH; i++) mreq(i, 0, 1, 16'(16'h0040 + i), 16'h0);
    pm(n + 1, 4'b0001, 16'hA000); pm(n + 3, 4'b0010, 16'hA001);
    pm(n + 5, 4'b0100, 16'hA002); pm(n + 7, 4'b1000, 16'hA003);
    ticks(8);
    n = cyc; mreq(1, 0, 1, 16'h0041, 16'h0); mreq(0, 0, 1, 16'h0040, 16'h0);
    pm(n + 1, 4'b0001, 16'hA000); pm(n + 3, 4'b0010, 16'hA001);
    ticks(5);

    // Lock contention on entry 5 and hand-over on release
    n = cyc; lreq(1, 1, 0, 4'd5); lreq(2, 1, 0, 4'd5); pl(n + 1, 4'b0010);
    ticks(2);
    n = cyc; lreq(1, 0, 1, 4'd5); pl(n + 1, 4'b0010); pl(n + 2, 4'b0100);
    ticks(3);

    // Unlock by a non-owner is acknowledged but leaves the owner in place
    n = cyc; lreq(0, 1, 0, 4'd7); pl(n + 1, 4'b0001);
    ticks(2);
    n = cyc; lreq(3, 0, 1, 4'd7); pl(n + 1, 4'b1000);
    ticks(2);
    lreq(1, 1, 0, 4'd7);
    ticks(3);
    n = cyc; lreq(0, 0, 1, 4'd7); pl(n + 1, 4'b0001); pl(n + 2, 4'b0010);
    ticks(3);

    // Lock and unlock together: unlock only, entry becomes free
    n = cyc; lreq(2, 1, 1, 4'd5); pl(n + 1, 4'b0100);
    ticks(2);
    n = cyc; lreq(3, 1, 0, 4'd5); pl(n + 1, 4'b1000);
    ticks(2);

    // A held lock does not slow down a concurrent write from another channel
    n = cyc; lreq(0, 1, 0, 4'd1); mreq(1, 1, 0, 16'h0001, 16'hBEEF);
    pl(n + 1, 4'b0001); pm(n + 1, 4'b0010, 16'h0);
    ticks(2);
    n = cyc; mreq(1, 0, 1, 16'h0001, 16'h0); pm(n + 1, 4'b0010, 16'hBEEF);
    ticks(2);
    n = cyc; lreq(0, 1, 0, 4'd1); pl(n + 1, 4'b0001);
    ticks(2);

    // Reset in the busy cycle of a channel 2 read drops its acknowledge
    mreq(2, 0, 1, 16'h0020, 16'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("midbusy_ac", 32'(ac), 32'h0);
    chk("midbusy_lock_ac", 32'(lock_ac), 32'h0);
    chk("midbusy_rd_dat", 32'(rd_dat), 32'h0);
    chk("midbusy_strobes", {30'h0, mem_re, mem_we}, 32'h0);
    ticks(2);
    reset = 1'b0;
    tick();
    n = cyc; lreq(0, 1, 0, 4'd7); lreq(2, 1, 0, 4'd1); pl(n + 1, 4'b0101);
    ticks(2);
    n = cyc; mreq(3, 0, 1, 16'h0043, 16'h0); mreq(0, 0, 1, 16'h0040, 16'h0);
    pm(n + 1, 4'b0001, 16'hA000); pm(n + 3, 4'b1000, 16'hA003);
    ticks(5);

    for (int i = 0; i < 20 && (mq.size() != 0 || lq.size() != 0); i++) tick();
    chk("drain_mem_queue", mq.size(), 32'h0);
    chk("drain_lock_queue", lq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of requesting core channels (2..8).
REQ-002 Parameter DW, default 16: data width; AW, default 16: address width.
REQ-003 Parameter LW, default 4: lock-address width; lock table has 2^LW entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 rd_req  in  NCH  per-channel read request, level, held until ac.
REQ-007 wr_req  in  NCH  per-channel write request, level, held until ac.
REQ-008 req_adr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW].
REQ-009 req_wdat  in  NCH*DW  per-channel write data, same packing.
REQ-010 ac  out  NCH  per-channel one-cycle access-complete pulse.
REQ-011 rd_dat  out  DW  read data, valid only in the cycle ac of a read channel is high.
REQ-012 lock_en / unlock_en  in  NCH each  per-channel lock / unlock request.
REQ-013 lock_adr  in  NCH*LW  per-channel lock address.
REQ-014 lock_ac  out  NCH  per-channel one-cycle lock/unlock acknowledge pulse.
REQ-015 mem_adr  out  AW; mem_wdat  out  DW; mem_we  out  1; mem_re  out  1  to single-port RAM.
REQ-016 mem_rdat  in  DW  RAM read data, valid one cycle after mem_re.

Function
REQ-017 Access FSM SHALL have states IDLE and BUSY only.
REQ-018 In IDLE with any rd_req|wr_req set, arbiter SHALL grant one channel by round-robin, starting search at (last_grant+1) mod NCH.
REQ-019 Grant cycle: mem_adr/mem_wdat SHALL come from granted channel combinationally; mem_re=rd_req, mem_we=wr_req of that channel; FSM -> BUSY, grant registered.
REQ-020 If a channel asserts both rd_req and wr_req, write SHALL take precedence; read served on a later grant.
REQ-021 BUSY: ac[grant] SHALL pulse for exactly one cycle; rd_dat=mem_rdat for reads; FSM -> IDLE; last_grant updated.
REQ-022 Latency: request seen in IDLE at cycle T -> ac at T+1; peak throughput one access per 2 cycles.
REQ-023 mem_re and mem_we SHALL be 0 outside grant cycles; rd_dat SHALL be 0 when no read ac is high.
REQ-024 Requests deasserted before ac are not supported; behaviour undefined but SHALL not deadlock FSM.
REQ-025 Lock table: per entry a valid bit and owner id (clog2(NCH) bits).
REQ-026 lock_en from channel i: if entry invalid or owned by i, set valid, owner=i, pulse lock_ac[i] next cycle; else no ack, request retried every cycle until granted.
REQ-027 Simultaneous lock_en on same free entry: lowest channel index wins; others wait.
REQ-028 unlock_en from channel i: if entry valid and owner==i, clear valid; lock_ac[i] pulses next cycle regardless (unlock of unowned entry is a no-op ack).
REQ-029 Lock decisions SHALL use table state before the current edge; an entry unlocked in cycle T is grantable to another channel in cycle T+1.
REQ-030 Channel asserting lock_en and unlock_en together: unlock only.
REQ-031 Locks are advisory: memory accesses SHALL NOT be blocked by lock state.
REQ-032 Lock and memory paths operate independently and concurrently.

Reset
REQ-033 Reset SHALL force FSM=IDLE, last_grant=NCH-1, all lock entries invalid, ac=0, lock_ac=0, rd_dat=0, mem_we=mem_re=0.
REQ-034 Reset asserted in BUSY SHALL drop the pending ac; no ac after reset release until a new grant.

Verification
REQ-035 Ch0 write 0x1234 to 0x0010, then ch0 read 0x0010 -> ac[0] at T+1 each; read returns rd_dat=0x1234.
REQ-036 All 4 channels request reads from reset -> grants in order 0,1,2,3, ac every 2 cycles, then wraps to 0.
REQ-037 Ch1 and ch2 lock_en adr 5 same cycle -> lock_ac[1] next cycle; ch2 waits; ch1 unlock at T -> lock_ac[2] at T+2.
REQ-038 Ch3 unlock adr 7 owned by ch0 -> lock_ac[3] pulses, entry 7 stays owned by ch0.
REQ-039 Reset asserted mid-BUSY for ch2 read -> no ac[2], all outputs 0, lock table empty.
REQ-040 Ch0 holds lock adr 1 while ch1 writes any address -> write completes in 2 cycles unaffected.
